// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, default taps and step function for the LFSR sequencer
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} lfsr_state_t;

  localparam logic [6:0] LFSR_TAPS_W7 = 7'h03;

  // Fibonacci step on a zero-extended state: lead bit enters at position width-1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic lead;
    lead = ^(state & taps);
    return (state >> 1) | ({31'd0, lead} << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// rtl/lfsr_seq_ctrl_if.sv - valid/ready word stream from the sequencer to its consumer
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 7
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with priority load and step enable
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_W7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] step;

  assign step = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), WIDTH));

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (enable_i) begin
      state_d = step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = step;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - run controller: loads the LFSR and streams count states over valid/ready
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_W7,
  parameter int               CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [CNTW-1:0]  count_i,
  input  logic             abort_i,
  lfsr_seq_ctrl_if.master  out_if,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o,
  output logic             lockup_o
);

  lfsr_state_t      state_q, state_d;
  logic [CNTW-1:0]  remaining_q, remaining_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic             lfsr_load;
  logic             lfsr_en;
  logic [WIDTH-1:0] lfsr_state;
  logic [WIDTH-1:0] lfsr_step;
  logic             xfer;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (lfsr_load),
    .enable_i (lfsr_en),
    .seed_i   (seed_q),
    .state_o  (lfsr_state),
    .next_o   (lfsr_step)
  );

  assign xfer = (state_q == RUN) && out_if.out_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    seed_d      = seed_q;
    wrap_d      = wrap_q;
    lockup_d    = lockup_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          seed_d      = seed_i;
          remaining_d = count_i;
          wrap_d      = 1'b0;
          lockup_d    = 1'b0;
          // A zero seed would lock the LFSR at zero, so the run ends without loading.
          if (seed_i == '0) begin
            lockup_d = 1'b1;
            state_d  = DONE;
          end else if (count_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
        state_d   = abort_i ? IDLE : RUN;
      end
      RUN: begin
        if (xfer) begin
          lfsr_en = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNTW'(1);
          end
          if (lfsr_step == seed_q) begin
            wrap_d = 1'b1;
          end
          if (remaining_q == CNTW'(1)) begin
            state_d = DONE;
          end
        end
        // Abort overrides completion; a same-cycle transfer is still consumed above.
        if (abort_i) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      seed_q      <= '0;
      wrap_q      <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      seed_q      <= seed_d;
      wrap_q      <= wrap_d;
      lockup_q    <= lockup_d;
    end
  end

  assign out_if.out_valid = (state_q == RUN);
  assign out_if.out_data  = lfsr_state;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign wrap_o           = wrap_q;
  assign lockup_o         = lockup_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - randomized self-checking bench for lfsr_seq_ctrl against a sequence model
module tb_lfsr_seq_ctrl;

  localparam int W  = 7;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  seed;
  logic [CW-1:0] count;
  logic          busy, done, wrap, lockup;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl_if #(.WIDTH(W)) out_if ();

  lfsr_seq_ctrl #(
    .WIDTH (W),
    .TAPS  (7'h03),
    .CNTW  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .seed_i   (seed),
    .count_i  (count),
    .abort_i  (abort),
    .out_if   (out_if),
    .busy_o   (busy),
    .done_o   (done),
    .wrap_o   (wrap),
    .lockup_o (lockup)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference step: shift right, new MSB is the parity of the tapped bits (taps = bits 0 and 1).
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
    int par;
    par = $countones(s & 7'h03) % 2;
    return (s >> 1) + ((par == 1) ? 7'h40 : 7'h00);
  endfunction

  task automatic run_case(input logic [W-1:0] s, input int cnt, input int rmode,
                          input int abort_at, input bit busy_start, input bit abort_with_start);
    logic [W-1:0] w[$];
    bit           seen[128];
    bit           normal, exp_wrap, exp_valid, exp_done, ended, aborting;
    int           xfers, n, nx, p, uniq;
    w.push_back(s);
    for (int i = 1; i <= cnt; i++) w.push_back(ref_step(w[i-1]));
    normal = (s != 0) && (cnt != 0);
    nx = !normal ? 0 : ((abort_at >= 0) ? abort_at + 1 : cnt);
    exp_wrap = 1'b0;
    for (int i = 1; i <= nx; i++) if (w[i] == s) exp_wrap = 1'b1;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    xfers = 0; n = 0; p = 0; uniq = 0; ended = 1'b0; aborting = 1'b0;

    @(negedge clk);
    start = 1'b1; seed = s; count = CW'(cnt); abort = abort_with_start; out_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; seed = W'($urandom); count = CW'($urandom);

    while (!ended && n < 1000) begin
      exp_valid = normal && (n >= 1) && (xfers < nx);
      exp_done  = normal ? (xfers == cnt) : (n == 0);
      case (rmode)
        0:       out_if.out_ready = 1'b1;
        1:       out_if.out_ready = ((p % 3) == 0);
        default: out_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (exp_valid && abort_at >= 0 && xfers == abort_at) begin
        out_if.out_ready = 1'b1;
        abort            = 1'b1;
        aborting         = 1'b1;
      end
      start = busy_start;
      if (busy_start) begin
        seed  = W'($urandom);
        count = CW'($urandom_range(1, 5));
      end
      check_eq("valid", out_if.out_valid, exp_valid);
      check_eq("busy", busy, 1);
      check_eq("done", done, exp_done);
      if (out_if.out_valid) begin
        if (xfers <= cnt) check_eq("data", out_if.out_data, w[xfers]);
        p++;
      end
      if (out_if.out_valid && out_if.out_ready) begin
        if (!seen[out_if.out_data]) uniq++;
        seen[out_if.out_data] = 1'b1;
        xfers++;
      end
      if (done || aborting) begin
        ended = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check_eq("timeout", ended, 1);
    @(negedge clk);
    abort = 1'b0;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_valid", out_if.out_valid, 0);
    check_eq("idle_done", done, 0);
    check_eq("xfers", xfers, nx);
    check_eq("wrap", wrap, exp_wrap);
    check_eq("lockup", lockup, (s == 0));
    if (cnt == 127 && abort_at < 0) check_eq("uniq", uniq, 127);
  endtask

  initial begin
    int rs, rc, ra;
    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; count = '0; out_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", out_if.out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_lockup", lockup, 0);
    check_eq("rst_data", out_if.out_data, 0);
    rst = 1'b0;

    run_case(7'h01, 3, 0, -1, 1'b0, 1'b0);
    run_case(7'h01, 127, 0, -1, 1'b0, 1'b0);
    run_case(7'h01, 126, 0, -1, 1'b0, 1'b0);
    run_case(7'h01, 4, 1, -1, 1'b0, 1'b0);
    run_case(7'h00, 5, 0, -1, 1'b0, 1'b0);
    run_case(7'h05, 5, 0, -1, 1'b0, 1'b0);
    run_case(7'h01, 10, 0, 1, 1'b1, 1'b0);
    run_case(7'h05, 0, 0, -1, 1'b0, 1'b0);
    run_case(7'h2A, 6, 2, -1, 1'b0, 1'b1);
    run_case(7'h33, 5, 0, 4, 1'b0, 1'b0);
    run_case(7'h01, 130, 2, -1, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      rs = $urandom_range(0, 127);
      rc = $urandom_range(0, 20);
      ra = (rs != 0 && rc != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, rc - 1) : -1;
      run_case(W'(rs), rc, 2, ra, 1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk);
    start = 1'b1; seed = 7'h01; count = CW'(200); out_if.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (135) @(negedge clk);
    check_eq("mid_wrap", wrap, 1);
    check_eq("mid_valid", out_if.out_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("mrst_valid", out_if.out_valid, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_wrap", wrap, 0);
    check_eq("mrst_data", out_if.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
